// File: rtl/mips_mem_arbiter_if.sv
// mips_mem_arbiter_if
// Bundles the CPU instruction/data memory ports and the shared memory port that
// mips_mem_arbiter sits between.
//   master : arbiter view. It drives the CPU responses and the shared Mem_* request.
//   slave  : environment view. The CPU drives the requests and the memory model
//            drives Mem_In/Mem_Ready.
// Signals:
//   DataMem_Read/Write/Address/Out  CPU data request (write is 4 byte lanes)
//   DataMem_In/Ready                data response, Ready is a one-cycle pulse
//   InstMem_Read/Address            CPU fetch request
//   InstMem_In/Ready                fetch response, Ready is a one-cycle pulse
//   Mem_Read/Write/Address/Out      shared memory request, held until Mem_Ready
//   Mem_In/Ready                    shared memory response
interface mips_mem_arbiter_if;
    logic        DataMem_Read;
    logic [3:0]  DataMem_Write;
    logic [29:0] DataMem_Address;
    logic [31:0] DataMem_Out;
    logic [31:0] DataMem_In;
    logic        DataMem_Ready;
    logic        InstMem_Read;
    logic [29:0] InstMem_Address;
    logic [31:0] InstMem_In;
    logic        InstMem_Ready;
    logic        Mem_Read;
    logic [3:0]  Mem_Write;
    logic [29:0] Mem_Address;
    logic [31:0] Mem_Out;
    logic [31:0] Mem_In;
    logic        Mem_Ready;

    modport master (
        input  DataMem_Read, DataMem_Write, DataMem_Address, DataMem_Out,
        output DataMem_In, DataMem_Ready,
        input  InstMem_Read, InstMem_Address,
        output InstMem_In, InstMem_Ready,
        output Mem_Read, Mem_Write, Mem_Address, Mem_Out,
        input  Mem_In, Mem_Ready
    );

    modport slave (
        output DataMem_Read, DataMem_Write, DataMem_Address, DataMem_Out,
        input  DataMem_In, DataMem_Ready,
        output InstMem_Read, InstMem_Address,
        input  InstMem_In, InstMem_Ready,
        input  Mem_Read, Mem_Write, Mem_Address, Mem_Out,
        output Mem_In, Mem_Ready
    );
endinterface

// File: rtl/mips_mem_arbiter.sv
// mips_mem_arbiter
// Two-to-one arbiter that shares one single-port memory between the MIPS32
// instruction-fetch port and data port. The winning request is registered and
// held on Mem_* until Mem_Ready. The response is then returned with a one-cycle
// Ready pulse, and one DONE cycle follows before the next grant.
// Ports:
//   clock  rising-edge clock
//   reset  asynchronous, active-high reset
//   bus    mips_mem_arbiter_if.master (CPU data/inst ports and the shared Mem_* port)
// Configuration:
//   MEM_ARB_ROUND_ROBIN_EN  defined: a 1-bit pointer alternates simultaneous requests,
//                           and data wins first after reset.
//                           undefined: fixed priority, data always beats instruction.
module mips_mem_arbiter (
    input  logic               clock,
    input  logic               reset,
    mips_mem_arbiter_if.master bus
);

    typedef enum logic [1:0] {StIdle, StGrantD, StGrantI, StDone} state_t;

    state_t      r_state;
    logic        r_mem_read;
    logic [3:0]  r_mem_write;
    logic [29:0] r_mem_address;
    logic [31:0] r_mem_out;
    logic [31:0] r_data_in;
    logic        r_data_ready;
    logic [31:0] r_inst_in;
    logic        r_inst_ready;

    logic w_data_req;
    logic w_inst_req;
    logic w_pick_data;

    assign w_data_req = bus.DataMem_Read | (|bus.DataMem_Write);
    assign w_inst_req = bus.InstMem_Read;

`ifdef MEM_ARB_ROUND_ROBIN_EN
    // Set when the instruction port should win the next tie.
    logic r_inst_next;

    assign w_pick_data = w_data_req & (~w_inst_req | ~r_inst_next);

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_inst_next <= 1'b0;
        end else if (r_state == StIdle && (w_data_req || w_inst_req)) begin
            // Favour whoever did not win this grant.
            r_inst_next <= w_pick_data;
        end
    end
`else
    assign w_pick_data = w_data_req;
`endif

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_state       <= StIdle;
            r_mem_read    <= 1'b0;
            r_mem_write   <= 4'h0;
            r_mem_address <= 30'h0;
            r_mem_out     <= 32'h0;
            r_data_in     <= 32'h0;
            r_data_ready  <= 1'b0;
            r_inst_in     <= 32'h0;
            r_inst_ready  <= 1'b0;
        end else begin
            unique case (r_state)
                StIdle: begin
                    if (w_pick_data) begin
                        r_state       <= StGrantD;
                        r_mem_address <= bus.DataMem_Address;
                        r_mem_out     <= bus.DataMem_Out;
                        // A read takes precedence; the write lanes are dropped.
                        r_mem_read    <= bus.DataMem_Read;
                        r_mem_write   <= bus.DataMem_Read ? 4'h0 : bus.DataMem_Write;
                    end else if (w_inst_req) begin
                        r_state       <= StGrantI;
                        r_mem_address <= bus.InstMem_Address;
                        r_mem_out     <= 32'h0;
                        r_mem_read    <= 1'b1;
                        r_mem_write   <= 4'h0;
                    end
                end
                StGrantD: begin
                    if (bus.Mem_Ready) begin
                        r_state      <= StDone;
                        r_data_in    <= bus.Mem_In;
                        r_data_ready <= 1'b1;
                        r_mem_read   <= 1'b0;
                        r_mem_write  <= 4'h0;
                    end
                end
                StGrantI: begin
                    if (bus.Mem_Ready) begin
                        r_state      <= StDone;
                        r_inst_in    <= bus.Mem_In;
                        r_inst_ready <= 1'b1;
                        r_mem_read   <= 1'b0;
                        r_mem_write  <= 4'h0;
                    end
                end
                StDone: begin
                    // Absorbs the cycle where the requester still sees its request high.
                    r_state      <= StIdle;
                    r_data_ready <= 1'b0;
                    r_inst_ready <= 1'b0;
                end
                default: r_state <= StIdle;
            endcase
        end
    end

    assign bus.Mem_Read      = r_mem_read;
    assign bus.Mem_Write     = r_mem_write;
    assign bus.Mem_Address   = r_mem_address;
    assign bus.Mem_Out       = r_mem_out;
    assign bus.DataMem_In    = r_data_in;
    assign bus.DataMem_Ready = r_data_ready;
    assign bus.InstMem_In    = r_inst_in;
    assign bus.InstMem_Ready = r_inst_ready;

endmodule

// File: tb/tb_mips_mem_arbiter.sv
// tb_mips_mem_arbiter
// Directed bench for mips_mem_arbiter. Inputs are driven 1 time unit after the
// rising edge, and outputs are sampled at the same point.
module tb_mips_mem_arbiter;

    logic clock;
    logic reset;
    int   n_total;
    int   n_bad;

    mips_mem_arbiter_if bus ();

    mips_mem_arbiter dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus.master)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic idle_inputs();
        bus.DataMem_Read    = 1'b0;
        bus.DataMem_Write   = 4'h0;
        bus.DataMem_Address = 30'h0;
        bus.DataMem_Out     = 32'h0;
        bus.InstMem_Read    = 1'b0;
        bus.InstMem_Address = 30'h0;
        bus.Mem_In          = 32'h0;
        bus.Mem_Ready       = 1'b0;
    endtask

    task automatic test_reset();
        idle_inputs();
        reset = 1'b1;
        tick();
        tick();
        n_total++;
        if ({bus.Mem_Read, bus.Mem_Write, bus.DataMem_Ready, bus.InstMem_Ready} !== 7'h0) begin
            n_bad++;
            $display("FAIL reset_ctrl: got %h want 00",
                     {bus.Mem_Read, bus.Mem_Write, bus.DataMem_Ready, bus.InstMem_Ready});
        end
        n_total++;
        if ({bus.Mem_Address, bus.Mem_Out} !== 62'h0) begin
            n_bad++;
            $display("FAIL reset_mem_bus: got %h want 0", {bus.Mem_Address, bus.Mem_Out});
        end
        n_total++;
        if ({bus.DataMem_In, bus.InstMem_In} !== 64'h0) begin
            n_bad++;
            $display("FAIL reset_rdata: got %h want 0", {bus.DataMem_In, bus.InstMem_In});
        end
        reset = 1'b0;
        tick();
    endtask

    task automatic test_fetch();
        bus.InstMem_Read    = 1'b1;
        bus.InstMem_Address = 30'h100;
        tick();
        // One grant cycle and two wait cycles, all with Mem_Ready low.
        for (int i = 0; i < 3; i++) begin
            n_total++;
            if (bus.Mem_Read !== 1'b1 || bus.Mem_Write !== 4'h0 || bus.Mem_Address !== 30'h100) begin
                n_bad++;
                $display("FAIL fetch_req[%0d]: got rd=%b wr=%h a=%h want rd=1 wr=0 a=100",
                         i, bus.Mem_Read, bus.Mem_Write, bus.Mem_Address);
            end
            if (i < 2) tick();
        end
        bus.Mem_Ready = 1'b1;
        bus.Mem_In    = 32'h2402_0005;
        tick();
        bus.Mem_Ready = 1'b0;
        bus.Mem_In    = 32'hDEAD_BEEF;
        n_total++;
        if (bus.InstMem_Ready !== 1'b1 || bus.InstMem_In !== 32'h2402_0005) begin
            n_bad++;
            $display("FAIL fetch_resp: got rdy=%b in=%h want rdy=1 in=24020005",
                     bus.InstMem_Ready, bus.InstMem_In);
        end
        n_total++;
        if (bus.DataMem_Ready !== 1'b0 || bus.Mem_Read !== 1'b0) begin
            n_bad++;
            $display("FAIL fetch_side: got drdy=%b mrd=%b want 0 0", bus.DataMem_Ready, bus.Mem_Read);
        end
        bus.InstMem_Read = 1'b0;
        tick();
        n_total++;
        if (bus.InstMem_Ready !== 1'b0 || bus.InstMem_In !== 32'h2402_0005) begin
            n_bad++;
            $display("FAIL fetch_pulse: got rdy=%b in=%h want rdy=0 in=24020005",
                     bus.InstMem_Ready, bus.InstMem_In);
        end
        tick();
    endtask

    task automatic test_byte_write();
        bus.DataMem_Write   = 4'b0010;
        bus.DataMem_Out     = 32'h0000_AB00;
        bus.DataMem_Address = 30'h801;
        tick();
        // Changes while granted must not reach the memory port.
        bus.DataMem_Out     = 32'h1111_1111;
        bus.DataMem_Address = 30'h3;
        bus.DataMem_Write   = 4'hF;
        for (int i = 0; i < 2; i++) begin
            n_total++;
            if (bus.Mem_Write !== 4'b0010 || bus.Mem_Out !== 32'h0000_AB00 ||
                bus.Mem_Address !== 30'h801 || bus.Mem_Read !== 1'b0) begin
                n_bad++;
                $display("FAIL wr_req[%0d]: got wr=%h out=%h a=%h rd=%b want 2 0000ab00 801 0",
                         i, bus.Mem_Write, bus.Mem_Out, bus.Mem_Address, bus.Mem_Read);
            end
            if (i == 0) tick();
        end
        bus.Mem_Ready = 1'b1;
        tick();
        bus.Mem_Ready = 1'b0;
        n_total++;
        if (bus.DataMem_Ready !== 1'b1 || bus.InstMem_Ready !== 1'b0 || bus.Mem_Write !== 4'h0) begin
            n_bad++;
            $display("FAIL wr_resp: got drdy=%b irdy=%b wr=%h want 1 0 0",
                     bus.DataMem_Ready, bus.InstMem_Ready, bus.Mem_Write);
        end
        bus.DataMem_Write = 4'h0;
        tick();
        n_total++;
        if (bus.DataMem_Ready !== 1'b0 || bus.Mem_Address !== 30'h801) begin
            n_bad++;
            $display("FAIL wr_after: got drdy=%b a=%h want 0 801", bus.DataMem_Ready, bus.Mem_Address);
        end
        tick();
    endtask

    task automatic test_read_write();
        bus.DataMem_Read    = 1'b1;
        bus.DataMem_Write   = 4'hF;
        bus.DataMem_Address = 30'h44;
        tick();
        n_total++;
        if (bus.Mem_Read !== 1'b1 || bus.Mem_Write !== 4'h0) begin
            n_bad++;
            $display("FAIL rw_cmd: got rd=%b wr=%h want 1 0", bus.Mem_Read, bus.Mem_Write);
        end
        bus.Mem_Ready = 1'b1;
        bus.Mem_In    = 32'hCAFE_0123;
        tick();
        bus.Mem_Ready = 1'b0;
        n_total++;
        if (bus.DataMem_Ready !== 1'b1 || bus.DataMem_In !== 32'hCAFE_0123) begin
            n_bad++;
            $display("FAIL rw_resp: got rdy=%b in=%h want 1 cafe0123", bus.DataMem_Ready, bus.DataMem_In);
        end
        bus.DataMem_Read  = 1'b0;
        bus.DataMem_Write = 4'h0;
        tick();
        tick();
    endtask

    task automatic test_back_to_back();
        logic exp_d [3];
`ifdef MEM_ARB_ROUND_ROBIN_EN
        exp_d = '{1'b1, 1'b0, 1'b1};
`else
        exp_d = '{1'b1, 1'b1, 1'b1};
`endif
        reset = 1'b1;
        tick();
        reset = 1'b0;
        bus.DataMem_Read    = 1'b1;
        bus.DataMem_Address = 30'h10;
        bus.InstMem_Read    = 1'b1;
        bus.InstMem_Address = 30'h20;
        for (int i = 0; i < 3; i++) begin
            tick();
            n_total++;
            if (bus.Mem_Read !== 1'b1 || bus.Mem_Address !== (exp_d[i] ? 30'h10 : 30'h20)) begin
                n_bad++;
                $display("FAIL b2b_grant[%0d]: got rd=%b a=%h want rd=1 a=%h",
                         i, bus.Mem_Read, bus.Mem_Address, exp_d[i] ? 30'h10 : 30'h20);
            end
            bus.Mem_Ready = 1'b1;
            tick();
            bus.Mem_Ready = 1'b0;
            n_total++;
            if (bus.DataMem_Ready !== exp_d[i] || bus.InstMem_Ready !== !exp_d[i]) begin
                n_bad++;
                $display("FAIL b2b_ready[%0d]: got d=%b i=%b want d=%b i=%b",
                         i, bus.DataMem_Ready, bus.InstMem_Ready, exp_d[i], !exp_d[i]);
            end
            if (i == 2) begin
                bus.DataMem_Read = 1'b0;
                bus.InstMem_Read = 1'b0;
            end
            tick();
        end
        tick();
        n_total++;
        if (bus.Mem_Read !== 1'b0 || bus.DataMem_Ready !== 1'b0 || bus.InstMem_Ready !== 1'b0) begin
            n_bad++;
            $display("FAIL b2b_quiet: got rd=%b d=%b i=%b want 0 0 0",
                     bus.Mem_Read, bus.DataMem_Ready, bus.InstMem_Ready);
        end
    endtask

    task automatic test_held_across_done();
        bus.InstMem_Read    = 1'b1;
        bus.InstMem_Address = 30'h33;
        tick();
        // Mem_Ready held for three cycles; only the first sample in the grant counts.
        bus.Mem_Ready = 1'b1;
        bus.Mem_In    = 32'h0000_0033;
        tick();
        n_total++;
        if (bus.InstMem_Ready !== 1'b1 || bus.InstMem_In !== 32'h0000_0033) begin
            n_bad++;
            $display("FAIL held_resp: got rdy=%b in=%h want 1 00000033", bus.InstMem_Ready, bus.InstMem_In);
        end
        bus.Mem_In = 32'h0000_0099;
        tick();
        n_total++;
        if (bus.Mem_Read !== 1'b0 || bus.InstMem_Ready !== 1'b0 || bus.InstMem_In !== 32'h0000_0033) begin
            n_bad++;
            $display("FAIL held_done: got rd=%b rdy=%b in=%h want 0 0 00000033",
                     bus.Mem_Read, bus.InstMem_Ready, bus.InstMem_In);
        end
        bus.InstMem_Read = 1'b0;
        tick();
        bus.Mem_Ready = 1'b0;
        n_total++;
        if (bus.Mem_Read !== 1'b0 || bus.InstMem_Ready !== 1'b0 || bus.DataMem_Ready !== 1'b0) begin
            n_bad++;
            $display("FAIL held_idle: got rd=%b irdy=%b drdy=%b want 0 0 0",
                     bus.Mem_Read, bus.InstMem_Ready, bus.DataMem_Ready);
        end
        tick();
    endtask

    task automatic test_reset_mid();
        bus.InstMem_Read    = 1'b1;
        bus.InstMem_Address = 30'h55;
        tick();
        tick();
        n_total++;
        if (bus.Mem_Read !== 1'b1 || bus.Mem_Address !== 30'h55) begin
            n_bad++;
            $display("FAIL rstmid_pre: got rd=%b a=%h want 1 55", bus.Mem_Read, bus.Mem_Address);
        end
        #2;
        reset = 1'b1;
        #1;
        n_total++;
        if ({bus.Mem_Read, bus.Mem_Write, bus.InstMem_Ready, bus.DataMem_Ready} !== 7'h0 ||
            bus.Mem_Address !== 30'h0 || bus.InstMem_In !== 32'h0 || bus.DataMem_In !== 32'h0) begin
            n_bad++;
            $display("FAIL rstmid_async: got rd=%b wr=%h irdy=%b a=%h iin=%h din=%h want all 0",
                     bus.Mem_Read, bus.Mem_Write, bus.InstMem_Ready, bus.Mem_Address,
                     bus.InstMem_In, bus.DataMem_In);
        end
        tick();
        reset            = 1'b0;
        bus.InstMem_Read = 1'b0;
        bus.Mem_Ready    = 1'b1;
        bus.Mem_In       = 32'hBAD0_BAD0;
        tick();
        bus.Mem_Ready = 1'b0;
        n_total++;
        if (bus.InstMem_Ready !== 1'b0 || bus.InstMem_In !== 32'h0 || bus.Mem_Read !== 1'b0) begin
            n_bad++;
            $display("FAIL rstmid_late: got rdy=%b in=%h rd=%b want 0 0 0",
                     bus.InstMem_Ready, bus.InstMem_In, bus.Mem_Read);
        end
        bus.InstMem_Read    = 1'b1;
        bus.InstMem_Address = 30'h77;
        tick();
        n_total++;
        if (bus.Mem_Read !== 1'b1 || bus.Mem_Address !== 30'h77) begin
            n_bad++;
            $display("FAIL rstmid_new_req: got rd=%b a=%h want 1 77", bus.Mem_Read, bus.Mem_Address);
        end
        bus.Mem_Ready = 1'b1;
        bus.Mem_In    = 32'h0800_0010;
        tick();
        bus.Mem_Ready = 1'b0;
        n_total++;
        if (bus.InstMem_Ready !== 1'b1 || bus.InstMem_In !== 32'h0800_0010) begin
            n_bad++;
            $display("FAIL rstmid_new_resp: got rdy=%b in=%h want 1 08000010",
                     bus.InstMem_Ready, bus.InstMem_In);
        end
        bus.InstMem_Read = 1'b0;
        tick();
        tick();
    endtask

    initial begin
        n_total = 0;
        n_bad   = 0;
        reset   = 1'b1;
        idle_inputs();
        test_reset();
        test_fetch();
        test_byte_write();
        test_read_write();
        test_back_to_back();
        test_held_across_done();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1);
    end

endmodule
